// File: rtl/router_fifo.sv
// rtl/router_fifo.sv - per-destination router output FIFO with header tagging and packet-end detection
module router_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             soft_reset,
   input  logic             write_enb,
   input  logic             read_enb,
   input  logic             lfd_state,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             empty,
   output logic             full,
   output logic             pkt_done
);

   localparam int CW = 7;
   localparam logic [AW:0] PTR_ONE = 1;
   localparam logic [CW-1:0] CNT_ONE = 1;

   logic [WIDTH:0]  mem [DEPTH];
   logic [AW:0]     wptr, rptr;
   logic [CW-1:0]   cnt;
   logic            lfd_d;
   logic            wr_ok, rd_ok;
   logic [WIDTH:0]  rd_entry;
   logic [CW-1:0]   hdr_len;

   assign empty    = (wptr == rptr);
   assign full     = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
   assign wr_ok    = write_enb && !full;
   assign rd_ok    = read_enb && !empty;
   assign rd_entry = mem[rptr[AW-1:0]];
   // Header length field counts payload bytes; the extra one accounts for parity.
   assign hdr_len  = CW'(rd_entry[WIDTH-1:2]) + CNT_ONE;

   always_ff @(posedge clk) begin
      if (wr_ok && !soft_reset)
         mem[wptr[AW-1:0]] <= {lfd_d, data_in};
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wptr  <= '0;
         rptr  <= '0;
         lfd_d <= 1'b0;
      end else if (soft_reset) begin
         wptr  <= '0;
         rptr  <= '0;
         lfd_d <= 1'b0;
      end else begin
         lfd_d <= lfd_state;
         if (wr_ok)
            wptr <= wptr + PTR_ONE;
         if (rd_ok)
            rptr <= rptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         data_out <= '0;
         cnt      <= '0;
         pkt_done <= 1'b0;
      end else if (soft_reset) begin
         data_out <= '0;
         cnt      <= '0;
         pkt_done <= 1'b0;
      end else begin
         pkt_done <= 1'b0;
         if (rd_ok) begin
            data_out <= rd_entry[WIDTH-1:0];
            if (rd_entry[WIDTH]) begin
               cnt <= hdr_len;
            end else if (cnt > CNT_ONE) begin
               cnt <= cnt - CNT_ONE;
            end else if (cnt == CNT_ONE) begin
               cnt      <= '0;
               pkt_done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_router_fifo.sv
// tb/tb_router_fifo.sv - directed self-checking bench for router_fifo
module tb_router_fifo;

   logic       clk;
   logic       resetn;
   logic       soft_reset;
   logic       write_enb;
   logic       read_enb;
   logic       lfd_state;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       empty;
   logic       full;
   logic       pkt_done;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic [7:0] d;
      bit         last;
   } ent_t;
   ent_t q[$];

   // {write_enb, lfd_state, last_byte, data}: three packets, each preceded by an lfd cycle
   localparam logic [10:0] SEQ [19] = '{
      11'h200, 11'h408, 11'h4A1, 11'h4A2, 11'h50B,
      11'h200, 11'h40C, 11'h4B1, 11'h4B2, 11'h4B3, 11'h5BC,
      11'h200, 11'h414, 11'h4C1, 11'h4C2, 11'h4C3, 11'h4C4, 11'h4C5, 11'h5D5
   };

   router_fifo #(.DEPTH(16), .WIDTH(8), .AW(4)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .soft_reset (soft_reset),
      .write_enb  (write_enb),
      .read_enb   (read_enb),
      .lfd_state  (lfd_state),
      .data_in    (data_in),
      .data_out   (data_out),
      .empty      (empty),
      .full       (full),
      .pkt_done   (pkt_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic lfd_pulse();
      lfd_state = 1'b1;
      tick();
      lfd_state = 1'b0;
   endtask

   task automatic wr(input logic [7:0] d);
      write_enb = 1'b1;
      data_in   = d;
      tick();
      write_enb = 1'b0;
   endtask

   task automatic rd(input logic [7:0] exp_d, input logic exp_done, input string tag);
      read_enb = 1'b1;
      tick();
      read_enb = 1'b0;
      chk({tag, "_data"}, data_out, exp_d);
      chk({tag, "_done"}, pkt_done, exp_done);
   endtask

   task automatic send_pkt1();
      lfd_pulse();
      wr(8'h0E);
      wr(8'h11);
      wr(8'h22);
      wr(8'h33);
      wr(8'h0E);
   endtask

   task automatic drain_pkt1(input string tag);
      rd(8'h0E, 1'b0, {tag, "_hdr"});
      rd(8'h11, 1'b0, {tag, "_p1"});
      rd(8'h22, 1'b0, {tag, "_p2"});
      rd(8'h33, 1'b0, {tag, "_p3"});
      rd(8'h0E, 1'b1, {tag, "_par"});
      chk({tag, "_empty"}, empty, 1'b1);
      tick();
      chk({tag, "_done_clr"}, pkt_done, 1'b0);
   endtask

   initial begin
      bit   rd_acc, wr_acc;
      ent_t e;
      int   pops, dones;

      resetn     = 1'b0;
      soft_reset = 1'b0;
      write_enb  = 1'b0;
      read_enb   = 1'b0;
      lfd_state  = 1'b0;
      data_in    = 8'h00;
      tick();
      tick();
      chk("rst_empty", empty, 1'b1);
      chk("rst_full", full, 1'b0);
      chk("rst_data", data_out, 8'h00);
      chk("rst_done", pkt_done, 1'b0);
      #2 resetn = 1'b1;
      tick();

      // single packet through an idle FIFO
      send_pkt1();
      chk("s1_not_empty", empty, 1'b0);
      drain_pkt1("s1");

      // fill to full, overflow write dropped
      for (int i = 0; i < 16; i++) begin
         chk("s2_not_full", full, 1'b0);
         wr(8'h40 + 8'(i));
      end
      chk("s2_full", full, 1'b1);
      wr(8'hAA);
      chk("s2_full_after_drop", full, 1'b1);

      // concurrent read/write while full: read wins, write dropped
      write_enb = 1'b1;
      read_enb  = 1'b1;
      data_in   = 8'hBB;
      tick();
      write_enb = 1'b0;
      read_enb  = 1'b0;
      chk("s3_full_rd_data", data_out, 8'h40);
      chk("s3_full_clear", full, 1'b0);
      for (int i = 1; i < 16; i++)
         rd(8'h40 + 8'(i), 1'b0, "s2_drain");
      chk("s2_empty", empty, 1'b1);

      // concurrent read/write while empty: write lands, no fall-through
      write_enb = 1'b1;
      read_enb  = 1'b1;
      data_in   = 8'hCC;
      tick();
      write_enb = 1'b0;
      read_enb  = 1'b0;
      chk("s3_empty_hold", data_out, 8'h4F);
      chk("s3_empty_wrote", empty, 1'b0);
      rd(8'hCC, 1'b0, "s3_cc");
      chk("s3_empty_end", empty, 1'b1);

      // three packets streamed with overlapping reads and writes
      pops  = 0;
      dones = 0;
      for (int cyc = 0; cyc < 48; cyc++) begin
         write_enb = (cyc < 19) ? SEQ[cyc][10] : 1'b0;
         lfd_state = (cyc < 19) ? SEQ[cyc][9] : 1'b0;
         data_in   = (cyc < 19) ? SEQ[cyc][7:0] : 8'h00;
         read_enb  = (cyc >= 2) && ((cyc >= 20) || (cyc % 2 == 1));
         rd_acc    = read_enb && (q.size() != 0);
         wr_acc    = write_enb && (q.size() < 16);
         tick();
         if (rd_acc) begin
            e = q.pop_front();
            pops++;
            chk("s4_data", data_out, e.d);
            chk("s4_done", pkt_done, e.last);
            if (pkt_done) dones++;
         end else begin
            chk("s4_done_idle", pkt_done, 1'b0);
         end
         if (wr_acc) begin
            e.d    = SEQ[cyc][7:0];
            e.last = SEQ[cyc][8];
            q.push_back(e);
         end
      end
      write_enb = 1'b0;
      lfd_state = 1'b0;
      read_enb  = 1'b0;
      chk("s4_pops", pops, 16);
      chk("s4_dones", dones, 3);
      chk("s4_empty", empty, 1'b1);

      // soft reset mid-packet: counter at 3 with 5 entries stored
      lfd_pulse();
      wr(8'h10);
      wr(8'hD1);
      wr(8'hD2);
      wr(8'hD3);
      wr(8'hD4);
      wr(8'h10 ^ 8'hD1 ^ 8'hD2 ^ 8'hD3 ^ 8'hD4);
      lfd_pulse();
      wr(8'h08);
      wr(8'hE1);
      rd(8'h10, 1'b0, "s5_hdr");
      rd(8'hD1, 1'b0, "s5_p1");
      rd(8'hD2, 1'b0, "s5_p2");
      soft_reset = 1'b1;
      write_enb  = 1'b1;
      read_enb   = 1'b1;
      data_in    = 8'h77;
      tick();
      soft_reset = 1'b0;
      write_enb  = 1'b0;
      read_enb   = 1'b0;
      chk("s5_empty", empty, 1'b1);
      chk("s5_full", full, 1'b0);
      chk("s5_data", data_out, 8'h00);
      chk("s5_done", pkt_done, 1'b0);
      tick();
      chk("s5_still_empty", empty, 1'b1);
      chk("s5_still_done", pkt_done, 1'b0);
      send_pkt1();
      drain_pkt1("s5_replay");

      // asynchronous reset between edges while full
      for (int i = 0; i < 16; i++)
         wr(8'h60 + 8'(i));
      chk("s6_full", full, 1'b1);
      #2 resetn = 1'b0;
      #1;
      chk("s6_empty", empty, 1'b1);
      chk("s6_full_clr", full, 1'b0);
      chk("s6_data", data_out, 8'h00);
      chk("s6_done", pkt_done, 1'b0);
      tick();
      resetn = 1'b1;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/router_fifo.md
Name: router_fifo

Overview:
- Per-destination output buffer of the 1x3 router. One instance per output port.
- Sits directly downstream of the router register stage: it captures the register stage's byte stream (header, payload, parity) and holds it until the destination drains it.
- Tags each stored byte with a header flag. On the read side it tracks packet length so it can flag the final (parity) byte of each packet.

Parameters:
- DEPTH, 16, number of entries; must be a power of 2, minimum 4.
- WIDTH, 8, data byte width; the stored entry is WIDTH+1 bits wide.
- AW, 4, pointer address width; must equal log2(DEPTH).

Ports:
- clk  input  1  rising-edge clock.
- resetn  input  1  asynchronous active-low reset.
- soft_reset  input  1  synchronous flush, asserted by the synchroniser on read timeout.
- write_enb  input  1  write request; data_in is captured this cycle.
- read_enb  input  1  read request from the destination.
- lfd_state  input  1  FSM load-first-data flag; arrives one cycle before the header appears on data_in.
- data_in  input  WIDTH  byte from the register stage (its d_out).
- data_out  output  WIDTH  registered read data.
- empty  output  1  no entries stored.
- full  output  1  DEPTH entries stored.
- pkt_done  output  1  one-cycle pulse; the parity byte of a packet was presented on data_out.

Behaviour:
- Reset (resetn=0, asynchronous):
  - Write and read pointers = 0; occupancy = 0; packet counter = 0; lfd_d = 0.
  - data_out = 0; pkt_done = 0; empty = 1; full = 0.
  - Memory contents are don't-care.
- lfd_d is lfd_state registered by one cycle. On every accepted write, entry = {lfd_d, data_in}; bit WIDTH is the header tag.
- Pointers are AW+1 bits, with the MSB used as a wrap bit.
  - empty = (wptr == rptr).
  - full = (addresses equal and wrap bits differ).
  - Both are combinational from the pointers.
- Write accepted iff write_enb && !full. Write while full is dropped: no pointer or memory change.
- Read accepted iff read_enb && !empty.
  - data_out is updated at the same clock edge with the entry at rptr; latency is 1 cycle from the read_enb sample.
  - Read while empty: data_out holds, and no counter or pointer change.
- Simultaneous write and read:
  - Both are accepted if their own conditions hold, evaluated on pre-edge flags.
  - When full, the read is accepted and the write is dropped that cycle.
  - When empty, the write is accepted and the read is ignored; there is no fall-through.
- Packet counter (7 bits), updated on accepted reads only:
  - Read entry has header tag = 1: counter <= data[7:2] + 1, i.e. payload length L plus the parity byte. pkt_done = 0.
  - Read entry has tag = 0 and counter > 1: counter <= counter - 1.
  - Read entry has tag = 0 and counter == 1: counter <= 0; pkt_done = 1 in the cycle data_out shows that byte.
  - Read entry has tag = 0 and counter == 0 (stray byte, no header): data_out still updates; counter stays 0; no pkt_done.
  - A header read while counter != 0 (truncated packet) reloads the counter. No pkt_done is issued for the abandoned packet.
- pkt_done is registered and deasserts after 1 cycle unless the next accepted read also completes a packet.
- soft_reset=1 at an edge:
  - Pointers, occupancy, packet counter and pkt_done = 0; data_out = 0; lfd_d = 0.
  - A write or read in the same cycle is discarded.
  - soft_reset has priority over all other activity. resetn has priority over soft_reset.
- Occupancy wraps correctly across the DEPTH boundary. A pointer wraps from DEPTH-1 to 0 and toggles its wrap bit.

Test Plan:
- Reset, then write header 8'h0E with lfd_state pulsed one cycle before it, then payload 8'h11, 8'h22, 8'h33, then parity 8'h0E^8'h11^8'h22^8'h33.
  - Read all 5 entries: data_out shows the same sequence, each 1 cycle after read_enb.
  - pkt_done pulses exactly on the parity byte.
  - empty = 1 after the last read.
- Write 16 bytes with no reads: full = 1 after the 16th. A 17th write of 8'hAA is dropped. Reading 16 entries returns the original 16 bytes and never 8'hAA.
- At full, assert write_enb and read_enb together: the read returns the oldest byte, the write is dropped, and full deasserts. Repeat at empty: the write lands, the read is ignored, and data_out holds.
- Stream 3 packets through with continuous concurrent read/write over 40+ cycles, forcing pointer wrap. Require 3 pkt_done pulses and byte-exact ordering.
- Mid-packet (counter = 3, 5 entries stored), assert soft_reset for 1 cycle: empty = 1, data_out = 0, and no pkt_done. A new packet then behaves as in the first scenario.
- Drop resetn asynchronously between clock edges while full: all outputs reach reset values immediately, without waiting for a clock edge.
